// File: rtl/arm_mc_controller_if.sv
// Control bundle between the multicycle ARM controller and its datapath.
// Latency: none; plain wires grouped for port convenience.
// Backpressure: none; the datapath samples every cycle.
//
// slave  : controller side (takes Instr/ALUFlags, drives all controls and Flags)
// master : datapath/test side (drives Instr/ALUFlags, observes controls)
interface arm_mc_controller_if;
   logic [31:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        IRWrite;
   logic        RegWrite;
   logic        MemWrite;
   logic        AdrSrc;
   logic [1:0]  RegSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ImmSrc;
   logic [1:0]  ALUControl;
   logic [1:0]  ResultSrc;
   logic [3:0]  Flags;

   modport slave (
      input  Instr, ALUFlags,
      output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, ResultSrc, Flags
   );

   modport master (
      output Instr, ALUFlags,
      input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUControl, ResultSrc, Flags
   );
endinterface

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: FSM sequencing, condition gating, NZCV flags.
// Latency: branch 3 cycles, data-processing/STR 4, LDR 5 (FETCH to FETCH).
// Backpressure: none; advances one state per clock, reset is synchronous.
//
// Ports: clk, reset (sync, active-high); bus (slave modport) carries Instr and
// ALUFlags in, and PC/IR/RF/memory enables, mux selects, ImmSrc, ALUControl
// and registered Flags out.
module arm_mc_controller #(
   parameter logic [1:0] IMMSRC_DP  = 2'b00,
   parameter logic [1:0] IMMSRC_MEM = 2'b01,
   parameter logic [1:0] IMMSRC_BR  = 2'b10
) (
   input  logic               clk,
   input  logic               reset,
   arm_mc_controller_if.slave bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   state_t      state, next_state;
   logic        condexr;
   logic [3:0]  flags_r;

   logic [3:0]  cond, rd;
   logic [1:0]  op;
   logic [5:0]  funct;
   logic        rd15;

   logic        nextpc, irw, regw, memw, branch, aluop;
   logic        alu_legal, alu_addsub, flagw, condex, pcs;
   logic [1:0]  alucontrol;

   logic        unused_instr;

   assign cond  = bus.Instr[31:28];
   assign op    = bus.Instr[27:26];
   assign funct = bus.Instr[25:20];
   assign rd    = bus.Instr[15:12];
   assign rd15  = (rd == 4'hF);
   assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:0]};

   // Condition evaluation against the registered flags (N Z C V = [3:0]).
   always_comb begin
      condex = 1'b0;
      case (cond)
         4'h0: condex =  flags_r[2];
         4'h1: condex = ~flags_r[2];
         4'h2: condex =  flags_r[1];
         4'h3: condex = ~flags_r[1];
         4'h4: condex =  flags_r[3];
         4'h5: condex = ~flags_r[3];
         4'h6: condex =  flags_r[0];
         4'h7: condex = ~flags_r[0];
         4'h8: condex =  flags_r[1] & ~flags_r[2];
         4'h9: condex = ~flags_r[1] |  flags_r[2];
         4'hA: condex =  (flags_r[3] == flags_r[0]);
         4'hB: condex =  (flags_r[3] != flags_r[0]);
         4'hC: condex = ~flags_r[2] & (flags_r[3] == flags_r[0]);
         4'hD: condex =  flags_r[2] | (flags_r[3] != flags_r[0]);
         4'hE: condex =  1'b1;
         default: condex = 1'b0;
      endcase
   end

   // Next-state and Moore decodes; illegal codes fall back to FETCH with
   // every enable low.
   always_comb begin
      next_state    = FETCH;
      nextpc        = 1'b0;
      irw           = 1'b0;
      regw          = 1'b0;
      memw          = 1'b0;
      branch        = 1'b0;
      aluop         = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ALUSrcA   = 1'b0;
      bus.ALUSrcB   = 2'b00;
      bus.ResultSrc = 2'b00;
      case (state)
         FETCH: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            irw           = 1'b1;
            nextpc        = 1'b1;
            next_state    = DECODE;
         end
         DECODE: begin
            bus.ALUSrcA   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            case (op)
               2'b01:   next_state = MEMADR;
               2'b00:   next_state = funct[5] ? EXECI : EXECR;
               2'b10:   next_state = BRANCH;
               default: next_state = FETCH;
            endcase
         end
         MEMADR: begin
            bus.ALUSrcB = 2'b01;
            next_state  = funct[0] ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            bus.AdrSrc = 1'b1;
            next_state = MEMWB;
         end
         MEMWB: begin
            bus.ResultSrc = 2'b01;
            regw          = 1'b1;
         end
         MEMWRITE: begin
            bus.AdrSrc = 1'b1;
            memw       = 1'b1;
         end
         EXECR: begin
            aluop      = 1'b1;
            next_state = ALUWB;
         end
         EXECI: begin
            bus.ALUSrcB = 2'b01;
            aluop       = 1'b1;
            next_state  = ALUWB;
         end
         ALUWB: begin
            regw = 1'b1;
         end
         BRANCH: begin
            bus.ALUSrcB   = 2'b01;
            bus.ResultSrc = 2'b10;
            branch        = 1'b1;
         end
         default: next_state = FETCH;
      endcase
   end

   // ALU decode; unrecognised commands fall back to ADD and never touch flags.
   always_comb begin
      alucontrol = 2'b00;
      alu_legal  = 1'b0;
      alu_addsub = 1'b0;
      if (aluop) begin
         case (funct[4:1])
            4'b0100: begin alucontrol = 2'b00; alu_legal = 1'b1; alu_addsub = 1'b1; end
            4'b0010: begin alucontrol = 2'b01; alu_legal = 1'b1; alu_addsub = 1'b1; end
            4'b0000: begin alucontrol = 2'b10; alu_legal = 1'b1; end
            4'b1100: begin alucontrol = 2'b11; alu_legal = 1'b1; end
            default: alucontrol = 2'b00;
         endcase
      end
   end

   assign flagw = aluop & funct[0] & condexr & alu_legal;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         flags_r <= 4'b0000;
         condexr <= 1'b0;
      end else begin
         state <= next_state;
         if (state == DECODE)
            condexr <= condex;
         if (flagw) begin
            flags_r[3:2] <= bus.ALUFlags[3:2];
            if (alu_addsub)
               flags_r[1:0] <= bus.ALUFlags[1:0];
         end
      end
   end

   // Writes to R15 become PC writes; everything except IR load is predicated.
   assign pcs          = (regw & rd15) | branch;
   assign bus.PCWrite  = ~reset & (nextpc | (pcs & condexr));
   assign bus.IRWrite  = ~reset & irw;
   assign bus.RegWrite = ~reset & regw & condexr & ~rd15;
   assign bus.MemWrite = ~reset & memw & condexr;

   assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
   assign bus.ALUControl = alucontrol;
   assign bus.Flags      = flags_r;

   always_comb begin
      case (op)
         2'b00:   bus.ImmSrc = IMMSRC_DP;
         2'b01:   bus.ImmSrc = IMMSRC_MEM;
         2'b10:   bus.ImmSrc = IMMSRC_BR;
         default: bus.ImmSrc = IMMSRC_DP;
      endcase
   end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: per-cycle expected control vectors
// are queued by the stimulus and checked by an independent negedge monitor.
module tb_arm_mc_controller;

   logic clk;
   logic reset;

   arm_mc_controller_if bus ();

   arm_mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      nm;
      logic [19:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   localparam logic [31:0] STR   = 32'hE5801000;
   localparam logic [31:0] LDR   = 32'hE5912004;
   localparam logic [31:0] ADDS  = 32'hE0910002;
   localparam logic [31:0] SUBEQ = 32'h00511002;
   localparam logic [31:0] BAL   = 32'hEA000003;
   localparam logic [31:0] BNE   = 32'h1A000003;
   localparam logic [31:0] ADDPC = 32'hE28FF008;
   localparam logic [31:0] NOP11 = 32'hEC000000;
   localparam logic [31:0] ORRS  = 32'hE1912002;

   // Field order: PCWrite IRWrite RegWrite MemWrite AdrSrc RegSrc ALUSrcA
   // ALUSrcB ImmSrc ALUControl ResultSrc Flags.
   function automatic logic [19:0] ev(input logic pcw, input logic irw, input logic rw,
                                      input logic mw, input logic adr, input logic [1:0] rs,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] im, input logic [1:0] ac,
                                      input logic [1:0] rsr, input logic [3:0] fl);
      return {pcw, irw, rw, mw, adr, rs, asa, asb, im, ac, rsr, fl};
   endfunction

   task automatic cyc(input logic rst, input logic [31:0] ins, input logic [3:0] af,
                      input string nm, input logic [19:0] e);
      exp_t x;
      reset        = rst;
      bus.Instr    = ins;
      bus.ALUFlags = af;
      x.nm = nm;
      x.v  = e;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t       x;
         logic [19:0] act;
         x   = exp_q.pop_front();
         act = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                bus.ResultSrc, bus.Flags};
         checks++;
         if (act !== x.v) begin
            errors++;
            $display("FAIL %s: got %b expected %b (PCW IRW RW MW Adr RegSrc SrcA SrcB Imm ALUC Res Flags)",
                     x.nm, act, x.v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      bus.Instr    = STR;
      bus.ALUFlags = 4'h0;
      @(posedge clk);
      #1;
      // Reset state: FETCH selects with enables forced low.
      cyc(1, STR,   4'h0, "rst_hold",      ev(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,2'b10,4'h0));
      // STR interrupted by reset in MEMWRITE.
      cyc(0, STR,   4'h0, "str_fetch",     ev(1,1,0,0,0,2'b10,1,2'b10,2'b01,2'b00,2'b10,4'h0));
      cyc(0, STR,   4'h0, "str_decode",    ev(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,2'b10,4'h0));
      cyc(0, STR,   4'h0, "str_memadr",    ev(0,0,0,0,0,2'b10,0,2'b01,2'b01,2'b00,2'b00,4'h0));
      cyc(1, STR,   4'h0, "str_memwr_rst", ev(0,0,0,0,1,2'b10,0,2'b00,2'b01,2'b00,2'b00,4'h0));
      cyc(1, STR,   4'h0, "str_rst2",      ev(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,2'b10,4'h0));
      // LDR: 5-cycle walk, RegWrite only in MEMWB.
      cyc(0, LDR,   4'h0, "ldr_fetch",     ev(1,1,0,0,0,2'b10,1,2'b10,2'b01,2'b00,2'b10,4'h0));
      cyc(0, LDR,   4'h0, "ldr_decode",    ev(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,2'b10,4'h0));
      cyc(0, LDR,   4'h0, "ldr_memadr",    ev(0,0,0,0,0,2'b10,0,2'b01,2'b01,2'b00,2'b00,4'h0));
      cyc(0, LDR,   4'h0, "ldr_memread",   ev(0,0,0,0,1,2'b10,0,2'b00,2'b01,2'b00,2'b00,4'h0));
      cyc(0, LDR,   4'h0, "ldr_memwb",     ev(0,0,1,0,0,2'b10,0,2'b00,2'b01,2'b00,2'b01,4'h0));
      // SUBEQS with Z=0: condition fails, no commit, flags untouched.
      cyc(0, SUBEQ, 4'h0, "subeq_fetch",   ev(1,1,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h0));
      cyc(0, SUBEQ, 4'h0, "subeq_decode",  ev(0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h0));
      cyc(0, SUBEQ, 4'hF, "subeq_execr",   ev(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b01,2'b00,4'h0));
      cyc(0, SUBEQ, 4'h0, "subeq_aluwb",   ev(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'h0));
      // ADDS: flags take 0110 after EXECR.
      cyc(0, ADDS,  4'h0, "adds_fetch",    ev(1,1,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h0));
      cyc(0, ADDS,  4'h0, "adds_decode",   ev(0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h0));
      cyc(0, ADDS,  4'h6, "adds_execr",    ev(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'h0));
      cyc(0, ADDS,  4'h0, "adds_aluwb",    ev(0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'h6));
      // B always: 3 cycles, PC written in BRANCH.
      cyc(0, BAL,   4'h0, "b_fetch",       ev(1,1,0,0,0,2'b01,1,2'b10,2'b10,2'b00,2'b10,4'h6));
      cyc(0, BAL,   4'h0, "b_decode",      ev(0,0,0,0,0,2'b01,1,2'b10,2'b10,2'b00,2'b10,4'h6));
      cyc(0, BAL,   4'h0, "b_branch",      ev(1,0,0,0,0,2'b01,0,2'b01,2'b10,2'b00,2'b10,4'h6));
      // BNE with Z=1: branch suppressed.
      cyc(0, BNE,   4'h0, "bne_fetch",     ev(1,1,0,0,0,2'b01,1,2'b10,2'b10,2'b00,2'b10,4'h6));
      cyc(0, BNE,   4'h0, "bne_decode",    ev(0,0,0,0,0,2'b01,1,2'b10,2'b10,2'b00,2'b10,4'h6));
      cyc(0, BNE,   4'h0, "bne_branch",    ev(0,0,0,0,0,2'b01,0,2'b01,2'b10,2'b00,2'b10,4'h6));
      // ADD R15 immediate: PC write instead of register write; S=0 keeps flags.
      cyc(0, ADDPC, 4'h0, "addpc_fetch",   ev(1,1,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h6));
      cyc(0, ADDPC, 4'h0, "addpc_decode",  ev(0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h6));
      cyc(0, ADDPC, 4'hF, "addpc_execi",   ev(0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,2'b00,4'h6));
      cyc(0, ADDPC, 4'h0, "addpc_aluwb",   ev(1,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'h6));
      // Op=11: FETCH, DECODE, back to FETCH with no writes.
      cyc(0, NOP11, 4'h0, "nop_fetch",     ev(1,1,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h6));
      cyc(0, NOP11, 4'h0, "nop_decode",    ev(0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h6));
      // SUBEQS with Z=1: passes, SUB updates all four flags.
      cyc(0, SUBEQ, 4'h0, "subeq2_fetch",  ev(1,1,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h6));
      cyc(0, SUBEQ, 4'h0, "subeq2_decode", ev(0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h6));
      cyc(0, SUBEQ, 4'h9, "subeq2_execr",  ev(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b01,2'b00,4'h6));
      cyc(0, SUBEQ, 4'h0, "subeq2_aluwb",  ev(0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'h9));
      // ORRS: only N and Z update, C and V keep 0 and 1.
      cyc(0, ORRS,  4'h0, "orrs_fetch",    ev(1,1,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h9));
      cyc(0, ORRS,  4'h0, "orrs_decode",   ev(0,0,0,0,0,2'b00,1,2'b10,2'b00,2'b00,2'b10,4'h9));
      cyc(0, ORRS,  4'h6, "orrs_execr",    ev(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b11,2'b00,4'h9));
      cyc(0, ORRS,  4'h0, "orrs_aluwb",    ev(0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,4'h5));

      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Multicycle control unit for the 32-bit ARM datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives ImmSrc to the immediate extender, plus mux selects and gated write enables to the PC, IR, register file, memory and ALU.
- Holds the NZCV flags register and a latched condition-pass bit, so predicated instructions commit correctly across cycles.

Parameters:
IMMSRC_DP, 2'b00, ImmSrc code for data-processing imm8
IMMSRC_MEM, 2'b01, ImmSrc code for LDR/STR imm12
IMMSRC_BR, 2'b10, ImmSrc code for branch imm24

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
Instr  input  32  IR contents: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
ALUFlags  input  4  NZCV from ALU, current cycle
PCWrite  output  1  PC register enable
IRWrite  output  1  instruction register enable
RegWrite  output  1  register file write enable
MemWrite  output  1  data memory write enable
AdrSrc  output  1  0=PC, 1=ALU result as memory address
RegSrc  output  2  [0]=read R15 (branch), [1]=read Rd as Ra2 (store)
ALUSrcA  output  1  0=RD1, 1=PC
ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=const 4
ImmSrc  output  2  extender select, = Op for Op in {00,01,10}, 00 for Op=11
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALU result direct
Flags  output  4  registered NZCV

Behaviour:
- Reset: clk and reset are a single clock domain; reset is synchronous and active-high.
  - On a clk edge with reset high: state<=FETCH, Flags<=0000, CondExR<=0.
  - While reset is high, PCWrite, IRWrite, RegWrite and MemWrite are forced 0, including a reset asserted mid-instruction (e.g. in MEMWRITE: no store, next state FETCH).
- State encoding (4 bits), transitions and Moore decodes. Any unlisted select is 0.
  - S0 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1 -> DECODE.
  - S1 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latch CondExR<=CondEx(Instr[31:28], Flags). Next state:
    - Op=01 -> MEMADR
    - Op=00 with Funct[5]=0 -> EXECR
    - Op=00 with Funct[5]=1 -> EXECI
    - Op=10 -> BRANCH
    - Op=11 -> FETCH (no-op)
  - S2 MEMADR: ALUSrcA=0, ALUSrcB=01 -> MEMREAD if Funct[0], else MEMWRITE.
  - S3 MEMREAD: AdrSrc=1 -> MEMWB.
  - S4 MEMWB: ResultSrc=01, RegW=1 -> FETCH.
  - S5 MEMWRITE: AdrSrc=1, MemW=1 -> FETCH.
  - S6 EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1 -> ALUWB.
  - S7 EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1 -> ALUWB.
  - S8 ALUWB: ResultSrc=00, RegW=1 -> FETCH.
  - S9 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
  - Illegal state codes -> FETCH, all enables 0.
- Gating (combinational):
  - PCS = (RegW & Rd==4'hF) | Branch
  - PCWrite = NextPC | (PCS & CondExR)
  - RegWrite = RegW & CondExR & ~(Rd==4'hF)
  - MemWrite = MemW & CondExR
  - IRWrite is ungated.
- ImmSrc is driven combinationally from Instr[27:26] in every state, so it is valid from DECODE onward.
- RegSrc is combinational from Op.
- ALUControl:
  - ALUOp=0 -> 00.
  - ALUOp=1 decodes Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11; any other code -> 00 with no flag write.
- Flags update, only at the end of EXECR/EXECI, when S=Funct[0]=1 and CondExR=1:
  - N and Z always update.
  - C and V update only for ADD/SUB.
- CondEx truth table, from registered Flags:
  - EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V
  - HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 -> 0
- Latency: 3 cycles for branch, 4 for DP and STR, 5 for LDR.
- A failed condition still walks every state but commits nothing except PC+4, which is written in FETCH.

Test Plan:
- Reset held 2 cycles mid-MEMWRITE of STR (Instr=E5801000) -> MemWrite=0 throughout; after release state=FETCH, IRWrite=1, Flags=0000.
- LDR Instr=E5912004 -> ImmSrc=01 from DECODE; states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in MEMWB, ResultSrc=01; 5 cycles.
- ADDS Instr=E0910002 with ALUFlags=0110 in EXECR -> ALUControl=00, Flags=0110 after EXECR, RegWrite=1 in ALUWB.
- SUBEQS R1 (Instr=00511002) with Flags Z=0 -> CondExR=0; RegWrite=0 in ALUWB; Flags unchanged; PCWrite only in FETCH.
- B (Instr=EA000003) -> ImmSrc=10, RegSrc[0]=1, PCWrite=1 in BRANCH, total 3 cycles; BNE with Z=1 -> PCWrite=0 in BRANCH.
- ADD R15 (Instr=E28FF008, Rd=15) -> PCWrite=1 and RegWrite=0 in ALUWB; Op=11 instruction -> FETCH, DECODE, FETCH with no writes.
